// File: rtl/reg_bank_arbiter_pkg.sv
// Shared constants for the arbitrated register bank: FSM encoding, requester ids, defaults.
package reg_bank_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 16;
    localparam int unsigned DEFAULT_NUM_REGS = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage

// File: rtl/reg_cell.sv
// One bank word: WIDTH-bit register with load enable and asynchronous active-low clear.
module reg_cell
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-port round-robin arbiter serialising single-word read/write transactions onto
// a bank of load-enabled registers; one transaction every three cycles.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter  int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic             WE_A,
    input  logic             WE_B,
    input  logic [AW-1:0]    ADDR_A,
    input  logic [AW-1:0]    ADDR_B,
    input  logic [WIDTH-1:0] DIN_A,
    input  logic [WIDTH-1:0] DIN_B,
    output logic             ACK_A,
    output logic             ACK_B,
    output logic [WIDTH-1:0] DOUT,
    output logic             BUSY
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NUM_REGS);

    logic [1:0]       state_q,    state_d;
    logic             pri_q,      pri_d;
    logic             win_q,      win_d;
    logic             cmd_we_q,   cmd_we_d;
    logic [AW-1:0]    cmd_addr_q, cmd_addr_d;
    logic [WIDTH-1:0] cmd_din_q,  cmd_din_d;
    logic [WIDTH-1:0] dout_q,     dout_d;
    logic             ack_a_q,    ack_a_d;
    logic             ack_b_q,    ack_b_d;
    logic             busy_q,     busy_d;

    logic             winner_c;
    logic             addr_ok_c;
    logic [WIDTH-1:0] rd_data_c;
    logic [NUM_REGS-1:0] load_c;
    logic [WIDTH-1:0] bank [NUM_REGS];

    // Register bank; only the addressed cell loads, and only during ACCESS of a write.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign load_c[i] = (state_q == ST_ACCESS) && cmd_we_q && (cmd_addr_q == AW'(i));

        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk_i  (CLK),
            .rst_ni (RST_N),
            .load_i (load_c[i]),
            .d_i    (cmd_din_q),
            .q_o    (bank[i])
        );
    end

    // Read mux; addresses past the bank read as zero.
    always_comb begin
        addr_ok_c = ({1'b0, cmd_addr_q} < NREGS_W);
        rd_data_c = '0;
        if (addr_ok_c) begin
            rd_data_c = bank[cmd_addr_q];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            pri_q      <= ID_A;
            win_q      <= ID_A;
            cmd_we_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_din_q  <= '0;
            dout_q     <= '0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pri_q      <= pri_d;
            win_q      <= win_d;
            cmd_we_q   <= cmd_we_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_din_q  <= cmd_din_d;
            dout_q     <= dout_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, arbitration and command latch.
    always_comb begin
        state_d    = state_q;
        pri_d      = pri_q;
        win_d      = win_q;
        cmd_we_d   = cmd_we_q;
        cmd_addr_d = cmd_addr_q;
        cmd_din_d  = cmd_din_q;
        dout_d     = dout_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        winner_c   = (REQ_A && (!REQ_B || (pri_q == ID_A))) ? ID_A : ID_B;

        case (state_q)
            ST_IDLE: begin
                if (REQ_A || REQ_B) begin
                    win_d      = winner_c;
                    pri_d      = ~winner_c;
                    cmd_we_d   = (winner_c == ID_A) ? WE_A   : WE_B;
                    cmd_addr_d = (winner_c == ID_A) ? ADDR_A : ADDR_B;
                    cmd_din_d  = (winner_c == ID_A) ? DIN_A  : DIN_B;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!cmd_we_q) begin
                    dout_d = rd_data_c;
                end
                ack_a_d = (win_q == ID_A);
                ack_b_d = (win_q == ID_B);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign ACK_A = ack_a_q;
    assign ACK_B = ack_b_q;
    assign DOUT  = dout_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: vector table, directed corner sequences,
// and randomized two-port traffic against a transaction-level model.
module tb_reg_bank_arbiter;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned AW       = 3;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             REQ_A, REQ_B, WE_A, WE_B;
    logic [AW-1:0]    ADDR_A, ADDR_B;
    logic [WIDTH-1:0] DIN_A, DIN_B;
    logic             ACK_A, ACK_B, BUSY;
    logic [WIDTH-1:0] DOUT;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             port;
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_dout;
    } vec_t;

    reg_bank_arbiter #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .WE_A(WE_A), .WE_B(WE_B),
        .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .DIN_A(DIN_A), .DIN_B(DIN_B),
        .ACK_A(ACK_A), .ACK_B(ACK_B), .DOUT(DOUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [WIDTH-1:0] din);
        if (port == 1'b0) begin
            REQ_A = req; WE_A = we; ADDR_A = addr; DIN_A = din;
        end else begin
            REQ_B = req; WE_B = we; ADDR_B = addr; DIN_B = din;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // One isolated transaction, started at a negedge with the DUT idle.
    task automatic single_txn(input vec_t v, input string tag);
        drive(v.port, 1'b1, v.we, v.addr, v.din);
        @(negedge CLK);
        chk({tag, "_busy_access"}, 32'(BUSY), 32'd1);
        chk({tag, "_noack_access"}, 32'({ACK_A, ACK_B}), 32'd0);
        @(negedge CLK);
        chk({tag, "_ack"}, 32'({ACK_A, ACK_B}), (v.port == 1'b0) ? 32'd2 : 32'd1);
        chk({tag, "_busy_resp"}, 32'(BUSY), 32'd1);
        chk({tag, "_dout"}, 32'(DOUT), 32'(v.exp_dout));
        drive(v.port, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        chk({tag, "_idle"}, 32'({ACK_A, ACK_B, BUSY}), 32'd0);
    endtask

    vec_t vecs[8];
    logic [WIDTH-1:0] mbank [NUM_REGS];

    initial begin
        int     ack_id[$];
        int     ack_cyc[$];
        int     a_step, b_step;
        logic   pend_a, pend_b, mpri, w, got;
        vec_t   ta, tb, tw, rv;
        logic [WIDTH-1:0] last_dout;
        int     exp_id[4];
        int     exp_cyc[4];

        RST_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_dout", 32'(DOUT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_acks", 32'({ACK_A, ACK_B}), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Vector table: DOUT holds its last read value across writes
        vecs[0] = '{1'b0, 1'b1, 3'd3, 16'h0C0C, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'h0C0C};
        vecs[2] = '{1'b1, 1'b0, 3'd5, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 3'd5, 16'hFFFF, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 3'd5, 16'h0000, 16'hFFFF};
        vecs[5] = '{1'b1, 1'b1, 3'd7, 16'h1234, 16'hFFFF};
        vecs[6] = '{1'b0, 1'b0, 3'd7, 16'h0000, 16'h1234};
        vecs[7] = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            single_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Both requesters hold REQ for four writes: A, B, A, B every 3 cycles
        do_reset();
        exp_id  = '{0, 1, 0, 1};
        exp_cyc = '{2, 5, 8, 11};
        a_step = 0; b_step = 0;
        drive(1'b0, 1'b1, 1'b1, 3'd0, 16'h1111);
        drive(1'b1, 1'b1, 1'b1, 3'd1, 16'h2222);
        for (int c = 1; c <= 14; c++) begin
            @(negedge CLK);
            if (ACK_A && ACK_B) chk("both_dual_ack", 32'd1, 32'd0);
            if (ACK_A) begin
                ack_id.push_back(0); ack_cyc.push_back(c);
                a_step++;
                if (a_step == 1) drive(1'b0, 1'b1, 1'b1, 3'd2, 16'h3333);
                else             drive(1'b0, 1'b0, 1'b0, '0, '0);
            end
            if (ACK_B) begin
                ack_id.push_back(1); ack_cyc.push_back(c);
                b_step++;
                if (b_step == 1) drive(1'b1, 1'b1, 1'b1, 3'd3, 16'h4444);
                else             drive(1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
        chk("both_ack_count", 32'(ack_id.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_id.size(); i++) begin
            chk($sformatf("both_order%0d", i), 32'(ack_id[i]), 32'(exp_id[i]));
            chk($sformatf("both_cycle%0d", i), 32'(ack_cyc[i]), 32'(exp_cyc[i]));
        end

        // Both read together: priority is back on A after A,B,A,B
        ack_id.delete(); ack_cyc.delete();
        drive(1'b0, 1'b1, 1'b0, 3'd0, '0);
        drive(1'b1, 1'b1, 1'b0, 3'd1, '0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            if (ACK_A) begin
                ack_id.push_back(0); ack_cyc.push_back(c);
                chk("rd_both_a_dout", 32'(DOUT), 32'h1111);
                drive(1'b0, 1'b0, 1'b0, '0, '0);
            end
            if (ACK_B) begin
                ack_id.push_back(1); ack_cyc.push_back(c);
                chk("rd_both_b_dout", 32'(DOUT), 32'h2222);
                drive(1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
        chk("rd_both_count", 32'(ack_id.size()), 32'd2);
        if (ack_id.size() == 2) begin
            chk("rd_both_first", 32'(ack_id[0]), 32'd0);
            chk("rd_both_first_cyc", 32'(ack_cyc[0]), 32'd2);
            chk("rd_both_second_cyc", 32'(ack_cyc[1]), 32'd5);
        end
        single_txn('{1'b0, 1'b0, 3'd2, 16'h0, 16'h3333}, "rd_reg2");
        single_txn('{1'b1, 1'b0, 3'd3, 16'h0, 16'h4444}, "rd_reg3");

        // Reset asserted during ACCESS of a write: no ACK, write lost
        drive(1'b0, 1'b1, 1'b1, 3'd1, 16'h4343);
        @(negedge CLK);
        chk("mid_rst_busy_before", 32'(BUSY), 32'd1);
        RST_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_ack", 32'({ACK_A, ACK_B}), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (ACK_A || ACK_B || BUSY) got = 1'b1;
        end
        chk("mid_rst_quiet", 32'(got), 32'd0);
        single_txn('{1'b0, 1'b0, 3'd1, 16'h0, 16'h0000}, "mid_rst_rd_reg1");

        // REQ held after ACK: identical transaction repeats 3 cycles later
        ack_cyc.delete();
        drive(1'b0, 1'b1, 1'b1, 3'd6, 16'h5A5A);
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            if (ACK_A) begin
                ack_cyc.push_back(c);
                if (ack_cyc.size() == 2) drive(1'b0, 1'b0, 1'b0, '0, '0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk("rep_count", 32'(ack_cyc.size()), 32'd2);
        if (ack_cyc.size() == 2) begin
            chk("rep_first", 32'(ack_cyc[0]), 32'd2);
            chk("rep_second", 32'(ack_cyc[1]), 32'd5);
        end
        single_txn('{1'b1, 1'b0, 3'd6, 16'h0, 16'h5A5A}, "rep_rd_reg6");

        // Randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < NUM_REGS; i++) mbank[i] = '0;
        mpri = 1'b0; last_dout = '0;
        pend_a = 1'b0; pend_b = 1'b0;
        ta = '{1'b0, 1'b0, '0, '0, '0};
        tb = '{1'b1, 1'b0, '0, '0, '0};
        for (int r = 0; r < 200; r++) begin
            if (!pend_a && ($urandom_range(0, 1) == 1)) begin
                pend_a = 1'b1;
                ta = '{1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NUM_REGS - 1)), WIDTH'($urandom), '0};
            end
            if (!pend_b && ($urandom_range(0, 1) == 1)) begin
                pend_b = 1'b1;
                tb = '{1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NUM_REGS - 1)), WIDTH'($urandom), '0};
            end
            if (!pend_a && !pend_b) begin
                pend_a = 1'b1;
                ta = '{1'b0, 1'b0, AW'($urandom_range(0, NUM_REGS - 1)), '0, '0};
            end
            drive(1'b0, pend_a, ta.we, ta.addr, ta.din);
            drive(1'b1, pend_b, tb.we, tb.addr, tb.din);

            w = (pend_a && pend_b) ? mpri : (pend_a ? 1'b0 : 1'b1);
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                @(negedge CLK);
                if (ACK_A || ACK_B) got = 1'b1;
            end
            chk($sformatf("rnd%0d_ack_seen", r), 32'(got), 32'd1);
            if (!got) break;
            chk($sformatf("rnd%0d_winner", r), 32'({ACK_A, ACK_B}), (w == 1'b0) ? 32'd2 : 32'd1);

            tw = (w == 1'b0) ? ta : tb;
            if (tw.we) mbank[tw.addr] = tw.din;
            else       last_dout = mbank[tw.addr];
            chk($sformatf("rnd%0d_dout", r), 32'(DOUT), 32'(last_dout));
            mpri = ~w;
            if (w == 1'b0) pend_a = 1'b0;
            else           pend_b = 1'b0;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge CLK);

        // Bank contents must match the model after random traffic
        for (int i = 0; i < NUM_REGS; i++) begin
            rv = '{1'b0, 1'b0, AW'(i), '0, mbank[i]};
            single_txn(rv, $sformatf("final_rd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
